regfile_ctrl: RTL and testbench

Sequencer and write-port owner for the single-read-port, single-write-port register file (registered read, write-through bypass). It zero-initialises all registers after reset and turns each two-operand request (rs1, rs2) into two back-to-back reads on the one read port. It returns both operands together through a valid/ready handshake, owns the write port for writeback, enforces x0 = 0, and forwards writebacks into already-captured operands. It sits between decode/issue and the register file.

---
 rtl/regfile_ctrl.sv | 152 +++++++++++++++
 tb/tb_regfile_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ctrl.sv
// Register-file sequencer: clear sweep, two-beat operand read, writeback
// port ownership with x0 masking and forwarding into captured operands.
module regfile_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_SIZE   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_rs1,
  input  logic [ADDR_WIDTH-1:0] req_rs2,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op1,
  output logic [DATA_WIDTH-1:0] op2,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_ready,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_din,
  input  logic [DATA_WIDTH-1:0] rf_dout,
  output logic                  init_done
);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    RD2,
    CAP,
    OUT
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST =
    ADDR_WIDTH'(RAM_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] rs1_q, rs1_d;
  logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic                  init_q, init_d;

  logic wb_commit;
  logic fwd1;
  logic fwd2;
  logic rs1_zero;
  logic rs2_zero;

  // x0 is never written, so a forward can never hit a zero operand
  assign wb_commit = wb_we && (wb_addr != '0);
  assign fwd1      = wb_commit && (wb_addr == rs1_q);
  assign fwd2      = wb_commit && (wb_addr == rs2_q);
  assign rs1_zero  = (rs1_q == '0);
  assign rs2_zero  = (rs2_q == '0);

  assign op1       = op1_q;
  assign op2       = op2_q;
  assign init_done = init_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    init_d        = init_q;
    req_ready     = 1'b0;
    op_valid      = 1'b0;
    wb_ready      = 1'b1;
    rf_we         = wb_commit;
    rf_write_addr = wb_addr;
    rf_din        = wb_data;
    rf_read_addr  = rs2_q;

    unique case (state_q)
      CLEAR: begin
        wb_ready      = 1'b0;
        rf_we         = 1'b1;
        rf_write_addr = cnt_q;
        rf_din        = '0;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          init_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE: begin
        req_ready    = 1'b1;
        rf_read_addr = req_rs1;
        if (req_valid) begin
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          state_d = RD2;
        end
      end
      RD2: begin
        rf_read_addr = rs2_q;
        if (rs1_zero)  op1_d = '0;
        else if (fwd1) op1_d = wb_data;
        else           op1_d = rf_dout;
        state_d = CAP;
      end
      CAP: begin
        if (rs2_zero)  op2_d = '0;
        else if (fwd2) op2_d = wb_data;
        else           op2_d = rf_dout;
        if (fwd1) op1_d = wb_data;
        state_d = OUT;
      end
      OUT: begin
        op_valid = 1'b1;
        if (fwd1) op1_d = wb_data;
        if (fwd2) op2_d = wb_data;
        if (op_ready) state_d = IDLE;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      init_q  <= init_d;
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a write-through register-file model.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs1, req_rs2;
  logic        op_valid, op_ready;
  logic [31:0] op1, op2;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        rf_we;
  logic [4:0]  rf_read_addr, rf_write_addr;
  logic [31:0] rf_din, rf_dout;
  logic        init_done;
  logic        preset;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_ctrl #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32),
    .RAM_SIZE  (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op1          (op1),
    .op2          (op2),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_ready     (wb_ready),
    .rf_we        (rf_we),
    .rf_read_addr (rf_read_addr),
    .rf_write_addr(rf_write_addr),
    .rf_din       (rf_din),
    .rf_dout      (rf_dout),
    .init_done    (init_done)
  );

  // register file: registered read, write-through on same-address write
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (preset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hBAD0_0000 | i;
    end else if (rf_we) begin
      mem[rf_write_addr] <= rf_din;
    end
    if (rf_we && rf_write_addr == rf_read_addr) rf_dout <= rf_din;
    else                                        rf_dout <= mem[rf_read_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      chk("clr_we", rf_we, 1);
      chk("clr_addr", rf_write_addr, i);
      chk("clr_din", rf_din, 0);
      chk("clr_init", init_done, 0);
      chk("clr_rrdy", req_ready, 0);
      chk("clr_wrdy", wb_ready, 0);
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    @(negedge clk);
    wb_we = 1'b0;
  endtask

  // issue a request; returns at the negedge after accept (state RD2)
  task automatic issue(input logic [4:0] a, input logic [4:0] b);
    req_valid = 1'b1; req_rs1 = a; req_rs2 = b;
    #1;
    chk("req_ready", req_ready, 1);
    chk("rd_addr1", rf_read_addr, a);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rd2_vld", op_valid, 0);
    chk("rd_addr2", rf_read_addr, b);
  endtask

  task automatic to_out();
    @(negedge clk);
    chk("cap_vld", op_valid, 0);
    @(negedge clk);
    chk("out_vld", op_valid, 1);
  endtask

  task automatic pop();
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    chk("pop_vld", op_valid, 0);
    chk("pop_rrdy", req_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; preset = 1'b1;
    req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0;
    op_ready = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    @(negedge clk);
    @(negedge clk);
    preset = 1'b0;
    chk("rst_vld", op_valid, 0);
    chk("rst_init", init_done, 0);
    chk("rst_op1", op1, 0);
    chk("rst_op2", op2, 0);
    chk("rst_waddr", rf_write_addr, 0);

    // sweep with a writeback request that must be ignored
    rst_n = 1'b1;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hFFFF_FFFF;
    sweep(32);
    wb_we = 1'b0;
    chk("init_done", init_done, 1);
    chk("idle_rrdy", req_ready, 1);
    chk("idle_wrdy", wb_ready, 1);

    issue(5'd7, 5'd9);
    to_out();
    chk("clr_op1", op1, 0);
    chk("clr_op2", op2, 0);
    pop();

    // basic read with stall
    wr(5'd5, 32'hDEAD_BEEF);
    wr(5'd6, 32'h1234_5678);
    issue(5'd5, 5'd6);
    to_out();
    for (int i = 0; i < 5; i++) begin
      chk("hold_vld", op_valid, 1);
      chk("hold_op1", op1, 32'hDEAD_BEEF);
      chk("hold_op2", op2, 32'h1234_5678);
      @(negedge clk);
    end
    pop();

    // x0
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1;
    chk("x0_rfwe", rf_we, 0);
    @(negedge clk);
    wb_we = 1'b0;
    issue(5'd0, 5'd0);
    to_out();
    chk("x0_op1", op1, 0);
    chk("x0_op2", op2, 0);
    pop();

    // forwarding at E1 into op1, then in OUT into op2
    wr(5'd3, 32'd1);
    wr(5'd4, 32'd2);
    issue(5'd3, 5'd4);
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hAA;
    @(negedge clk);
    wb_we = 1'b0;
    chk("cap_vld", op_valid, 0);
    @(negedge clk);
    chk("fwd_vld", op_valid, 1);
    chk("fwd_op1", op1, 32'hAA);
    chk("fwd_op2a", op2, 32'd2);
    wr(5'd4, 32'hBB);
    chk("fwdo_vld", op_valid, 1);
    chk("fwdo_op1", op1, 32'hAA);
    chk("fwdo_op2", op2, 32'hBB);
    pop();

    // forwarding at the CAP edge into op2
    wr(5'd11, 32'h1111);
    issue(5'd10, 5'd11);
    @(negedge clk);
    wb_we = 1'b1; wb_addr = 5'd11; wb_data = 32'hC0DE;
    @(negedge clk);
    wb_we = 1'b0;
    chk("capf_vld", op_valid, 1);
    chk("capf_op1", op1, 0);
    chk("capf_op2", op2, 32'hC0DE);
    pop();

    // same address, write at the accept edge through the bypass
    wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h55;
    issue(5'd8, 5'd8);
    wb_we = 1'b0;
    to_out();
    chk("same_op1", op1, 32'h55);
    chk("same_op2", op2, 32'h55);
    pop();

    // reset while in OUT
    issue(5'd5, 5'd6);
    to_out();
    chk("pre_op1", op1, 32'hDEAD_BEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("rout_vld", op_valid, 0);
    chk("rout_op1", op1, 0);
    chk("rout_waddr", rf_write_addr, 0);
    chk("rout_init", init_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(10);
    chk("mid_addr", rf_write_addr, 10);

    // reset mid-clear at counter 10
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_addr", rf_write_addr, 0);
    chk("rmid_init", init_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(32);
    chk("re_init", init_done, 1);
    issue(5'd5, 5'd6);
    to_out();
    chk("re_op1", op1, 0);
    chk("re_op2", op2, 0);
    pop();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
